mem_wb_data_stage: RTL

Memory stage of the ARM-PPU pipeline: sits between the EX/MEM pipeline register and the register-file write-back port. It holds the 256-byte data memory, performs word/byte loads and stores, and registers the write-back bundle, absorbing the MEM/WB pipeline register. Loads return data to write-back one clock after the access, exactly as the MEM/WB register would.

---
 rtl/mem_wb_data_stage_pkg.sv | 13 +
 rtl/mem_wb_data_stage_data_ram_be.sv | 41 ++++
 rtl/mem_wb_data_stage.sv | 84 ++++++++
 3 files changed

// File: rtl/mem_wb_data_stage_pkg.sv
// Shared constants for the ARM-PPU memory stage: access-size and direction
// encodings, plus the default data-memory address width.
package mem_wb_data_stage_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W_DEF = 8;

    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;
    localparam logic RW_READ   = 1'b0;
    localparam logic RW_WRITE  = 1'b1;

endpackage

// File: rtl/mem_wb_data_stage_data_ram_be.sv
// data_ram_be: byte-wide data memory with big-endian word/byte write lanes and
// combinational big-endian word read. Contents are not reset.
module data_ram_be
    import mem_wb_data_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              we,
    input  logic              size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [7:0]        Mem [0:2**ADDR_W-1];
    logic [ADDR_W-1:0] a1, a2, a3;

    // Byte lanes wrap naturally through the ADDR_W-bit adders.
    always_comb begin
        a1 = addr + ADDR_W'(1);
        a2 = addr + ADDR_W'(2);
        a3 = addr + ADDR_W'(3);
    end

    always_ff @(posedge Clk) begin
        if (we) begin
            if (size == SIZE_BYTE) begin
                Mem[addr] <= wdata[7:0];
            end else begin
                Mem[addr] <= wdata[31:24];
                Mem[a1]   <= wdata[23:16];
                Mem[a2]   <= wdata[15:8];
                Mem[a3]   <= wdata[7:0];
            end
        end
    end

    assign rdata = {Mem[addr], Mem[a1], Mem[a2], Mem[a3]};

endmodule

// File: rtl/mem_wb_data_stage.sv
// Memory stage with absorbed MEM/WB register: data RAM access, write-back select
// and registered pass-through. Optional misalignment check under DMEM_ALIGN_CHECK_EN.
module mem_wb_data_stage
    import mem_wb_data_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              MEM_E,
    input  logic              MEM_RW,
    input  logic              MEM_Size,
    input  logic              MEM_load_instr,
    input  logic              MEM_RF_enable,
    input  logic [3:0]        RD_in,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] WB_data,
    output logic [3:0]        WB_RD,
    output logic              WB_RF_enable
`ifdef DMEM_ALIGN_CHECK_EN
   ,output logic              align_err
`endif
);

    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] wb_next;
    logic              mem_we;
    logic              rf_next;
`ifdef DMEM_ALIGN_CHECK_EN
    logic              misalign;
`endif

    data_ram_be #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .Clk  (Clk),
        .we   (mem_we),
        .size (MEM_Size),
        .addr (Address),
        .wdata(DataIn),
        .rdata(rd_word)
    );

    always_comb begin
        load_data = (MEM_Size == SIZE_BYTE) ? {{(DATA_W-8){1'b0}}, rd_word[31:24]} : rd_word;
        // Gating with Clr drops stores whose edge arrives during reset.
        mem_we    = Clr && MEM_E && (MEM_RW == RW_WRITE);
        rf_next   = MEM_RF_enable;
        if (MEM_load_instr)
            wb_next = (MEM_E && (MEM_RW == RW_READ)) ? load_data : '0;
        else
            wb_next = {{(DATA_W-ADDR_W){1'b0}}, Address};
`ifdef DMEM_ALIGN_CHECK_EN
        misalign = MEM_E && (MEM_Size == SIZE_WORD) && (Address[1:0] != 2'b00);
        if (misalign) begin
            mem_we  = 1'b0;
            wb_next = '0;
            rf_next = 1'b0;
        end
`endif
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            WB_data      <= '0;
            WB_RD        <= '0;
            WB_RF_enable <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
            align_err    <= 1'b0;
`endif
        end else begin
            WB_data      <= wb_next;
            WB_RD        <= RD_in;
            WB_RF_enable <= rf_next;
`ifdef DMEM_ALIGN_CHECK_EN
            if (misalign)
                align_err <= 1'b1;
`endif
        end
    end

endmodule
